// File: rtl/sevenseg_scanner.sv
// Multiplexed seven-segment scanner: hex decode, decimal points, leading-zero
// blanking, PWM brightness and a frame-synchronous double-buffered update port.
module sevenseg_scanner #(
   parameter int NUM_DIGITS     = 4,
   parameter int DIV_W          = 12,
   parameter int BRIGHT_W       = 3,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    upd_valid,
   output logic                    upd_ready,
   input  logic [4*NUM_DIGITS-1:0] upd_value,
   input  logic [NUM_DIGITS-1:0]   upd_dp,
   input  logic                    lz_blank,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [7:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   dig_out,
   output logic                    frame_done
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [7:0]            SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF  = DIG_ACTIVE_LOW ? '1 : '0;

   logic [DIV_W-1:0]        presc;
   logic [IDX_W-1:0]        idx;
   logic                    tick;
   logic                    wrap_tick;
   logic                    pend;
   logic [4*NUM_DIGITS-1:0] pend_value;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic [4*NUM_DIGITS-1:0] disp_value;
   logic [NUM_DIGITS-1:0]   disp_dp;

   logic [3:0]              nib_p0;
   logic                    dp_p0;
   logic                    blank_p0;
   logic                    pwm_on_p0;
   logic [NUM_DIGITS-1:0]   upper_zero;
   logic [7:0]              seg_p0;
   logic [NUM_DIGITS-1:0]   dig_p0;

   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      case (nib)
         4'h0: hex_decode = 7'h3F;
         4'h1: hex_decode = 7'h06;
         4'h2: hex_decode = 7'h5B;
         4'h3: hex_decode = 7'h4F;
         4'h4: hex_decode = 7'h66;
         4'h5: hex_decode = 7'h6D;
         4'h6: hex_decode = 7'h7D;
         4'h7: hex_decode = 7'h07;
         4'h8: hex_decode = 7'h7F;
         4'h9: hex_decode = 7'h6F;
         4'hA: hex_decode = 7'h77;
         4'hB: hex_decode = 7'h7C;
         4'hC: hex_decode = 7'h39;
         4'hD: hex_decode = 7'h5E;
         4'hE: hex_decode = 7'h79;
         default: hex_decode = 7'h71;
      endcase
   endfunction

   assign tick      = &presc;
   assign wrap_tick = tick && (idx == LAST_IDX);
   assign upd_ready = ~pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc      <= '0;
         idx        <= '0;
         frame_done <= 1'b0;
      end else begin
         presc      <= presc + DIV_W'(1);
         frame_done <= wrap_tick;
         if (tick)
            idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
   end

   // Pending buffer moves to the display only on a frame wrap, so a frame never tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend       <= 1'b0;
         pend_value <= '0;
         pend_dp    <= '0;
         disp_value <= '0;
         disp_dp    <= '0;
      end else begin
         if (wrap_tick && pend) begin
            disp_value <= pend_value;
            disp_dp    <= pend_dp;
            pend       <= 1'b0;
         end
         if (upd_valid && upd_ready) begin
            pend_value <= upd_value;
            pend_dp    <= upd_dp;
            pend       <= 1'b1;
         end
      end
   end

   // Stage p0: select and decode the current digit
   always_comb begin
      nib_p0     = 4'h0;
      dp_p0      = 1'b0;
      blank_p0   = 1'b0;
      dig_p0     = '0;
      upper_zero = '0;
      pwm_on_p0  = (&brightness) || (presc[DIV_W-1 -: BRIGHT_W] < brightness);
      upper_zero[NUM_DIGITS-1] = (disp_value[4*(NUM_DIGITS-1) +: 4] == 4'h0);
      for (int i = NUM_DIGITS - 2; i >= 0; i--)
         upper_zero[i] = upper_zero[i+1] && (disp_value[4*i +: 4] == 4'h0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            nib_p0    = disp_value[4*i +: 4];
            dp_p0     = disp_dp[i];
            blank_p0  = lz_blank && (i != 0) && upper_zero[i];
            dig_p0[i] = pwm_on_p0;
         end
      end
      seg_p0 = {dp_p0, blank_p0 ? 7'h00 : hex_decode(nib_p0)};
   end

   // Stage p1: registered pins at the configured polarity
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_out <= SEG_OFF;
         dig_out <= DIG_OFF;
      end else begin
         seg_out <= seg_p0 ^ SEG_OFF;
         dig_out <= dig_p0 ^ DIG_OFF;
      end
   end

endmodule
